sw_txn_launcher: RTL and testbench

Board-level front-end that turns a raw push-button press plus slide-switch settings into exactly one bus transaction request for the Bus-A master interface. It debounces and synchronises the inputs, builds the 16-bit device/memory address, issues a one-cycle `mwvalid` pulse, and tracks completion. It then latches read data and drives status outputs, with a timeout so the board never hangs. It sits between the FPGA pins and `master_interface`, replacing ad-hoc start-pulse logic in FPGA test tops.

---
 rtl/sw_txn_launcher.sv | 152 +++++++++++++++
 tb/tb_sw_txn_launcher.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_txn_launcher.sv
// Button/switch front-end for the Bus-A master: synchronises and debounces the
// inputs, then issues one request per press and tracks completion or timeout.
module sw_txn_launcher #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode_sw,
  input  logic [1:0]            device_addr_sw,
  input  logic [5:0]            slave_mem_addr_sw,
  input  logic [DATA_WIDTH-1:0] m_write_data_sw,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [DATA_WIDTH-1:0] mwdata,
  output logic                  wen,
  output logic                  mwvalid,
  input  logic                  mready,
  input  logic                  mrvalid,
  input  logic [DATA_WIDTH-1:0] mrdata,
  output logic [DATA_WIDTH-1:0] m_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);
  localparam int SW  = 10 + DATA_WIDTH;
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TOW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE} state_t;

  logic [SW-1:0]         r_sync1, r_sync2;
  logic [DBW-1:0]        r_db_cnt;
  logic                  r_db_lvl, r_db_prev;
  logic [TOW-1:0]        r_to_cnt;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [DATA_WIDTH-1:0] r_mwdata, r_rdata;
  logic                  r_wen, r_mwvalid, r_busy, r_done, r_tmo;

  logic                  w_start_s, w_mode_s, w_press, w_to_hit;
  logic [1:0]            w_dev_s;
  logic [5:0]            w_mem_s;
  logic [DATA_WIDTH-1:0] w_wdata_s;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign {w_start_s, w_mode_s, w_dev_s, w_mem_s, w_wdata_s} = r_sync2;
  assign w_press  = r_db_lvl & ~r_db_prev;
  assign w_to_hit = (r_to_cnt == TO_MAX);

  always_comb begin
    w_addr        = '0;
    w_addr[11:10] = w_dev_s;
    w_addr[5:0]   = w_mem_s;
  end

  // Counter only runs while the synchronised button disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db_cnt  <= '0;
      r_db_lvl  <= 1'b0;
      r_db_prev <= 1'b0;
    end else begin
      r_sync1   <= {start, mode_sw, device_addr_sw, slave_mem_addr_sw, m_write_data_sw};
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_lvl;
      if (w_start_s != r_db_lvl) begin
        if (r_db_cnt == DB_MAX) begin
          r_db_lvl <= w_start_s;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_maddr   <= '0;
      r_mwdata  <= '0;
      r_wen     <= 1'b0;
      r_mwvalid <= 1'b0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_mwvalid <= 1'b0;
      if (r_state == S_WAIT_ACC || r_state == S_WAIT_DONE)
        r_to_cnt <= r_to_cnt + TOW'(1);
      case (r_state)
        S_IDLE: if (w_press) begin
          r_maddr  <= w_addr;
          r_mwdata <= w_wdata_s;
          r_wen    <= w_mode_s;
          r_done   <= 1'b0;
          r_tmo    <= 1'b0;
          r_busy   <= 1'b1;
          r_state  <= S_ARM;
        end
        S_ARM: if (mready) begin
          r_mwvalid <= 1'b1;
          r_state   <= S_ISSUE;
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_ACC;
        end
        // Completion is checked before the timeout so a late response still counts.
        S_WAIT_ACC, S_WAIT_DONE: begin
          if (!r_wen && mrvalid) begin
            r_rdata <= mrdata;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wen && mready && r_state == S_WAIT_DONE) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_to_hit) begin
            r_tmo   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_state == S_WAIT_ACC && !mready) begin
            r_state <= S_WAIT_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign maddr       = r_maddr;
  assign mwdata      = r_mwdata;
  assign wen         = r_wen;
  assign mwvalid     = r_mwvalid;
  assign m_read_data = r_rdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_tmo;
endmodule

// File: tb/tb_sw_txn_launcher.sv
// Bench for sw_txn_launcher: table of transactions with a bus-side model,
// a request scoreboard, and hand sequences for bounce, ARM hold and reset.
module tb_sw_txn_launcher;
  logic        clk = 1'b0;
  logic        rstn, start, mode_sw, mready, mrvalid;
  logic [1:0]  device_addr_sw;
  logic [5:0]  slave_mem_addr_sw;
  logic [7:0]  m_write_data_sw, mrdata, mwdata, m_read_data;
  logic [15:0] maddr;
  logic        wen, mwvalid, busy, done, timeout_err;

  always #5 clk = ~clk;

  sw_txn_launcher #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode_sw(mode_sw),
    .device_addr_sw(device_addr_sw), .slave_mem_addr_sw(slave_mem_addr_sw),
    .m_write_data_sw(m_write_data_sw), .maddr(maddr), .mwdata(mwdata), .wen(wen),
    .mwvalid(mwvalid), .mready(mready), .mrvalid(mrvalid), .mrdata(mrdata),
    .m_read_data(m_read_data), .busy(busy), .done(done), .timeout_err(timeout_err));

  typedef struct {
    logic mode; logic [1:0] dev; logic [5:0] mem; logic [7:0] wdata;
    logic [7:0] rdata; bit tmo; logic [15:0] exp_addr;
  } vec_t;
  typedef struct { logic [15:0] addr; logic [7:0] wdata; logic wen; } exp_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_checks = 0, n_fail = 0, n_pulse = 0;
  logic prev_mwv = 1'b0;
  logic [7:0] last_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every bench cycle goes through here so each request strobe is scored.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (mwvalid === 1'b1) begin
      n_pulse++;
      chk("mwvalid_with_mready", 32'(mready), 32'd1);
      chk("mwvalid_single_cycle", 32'(prev_mwv), 32'd0);
      if (sb_q.size() == 0) chk("unexpected_mwvalid", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("maddr", 32'(maddr), 32'(e.addr));
        chk("mwdata", 32'(mwdata), 32'(e.wdata));
        chk("wen", 32'(wen), 32'(e.wen));
      end
    end
    prev_mwv = mwvalid;
  endtask

  task automatic set_sw(input logic m, input logic [1:0] d, input logic [5:0] a, input logic [7:0] w);
    exp_t e;
    mode_sw = m; device_addr_sw = d; slave_mem_addr_sw = a; m_write_data_sw = w;
    e.addr = {4'h0, d, 4'h0, a}; e.wdata = w; e.wen = m;
    sb_q.push_back(e);
    repeat (3) tick();
  endtask

  task automatic wait_mwvalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mwvalid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("mwvalid_arrival", 32'd0, 32'd1);
  endtask

  task automatic wait_busy();
    int i;
    i = 0;
    while (!busy && i < 60) begin tick(); i++; end
    chk("busy_arrival", 32'(busy), 32'd1);
  endtask

  // Called on the ISSUE cycle: master accepts, stays busy 3 cycles, then returns ready.
  task automatic finish_write(input string tag);
    tick(); mready = 1'b0;
    repeat (3) tick();
    chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
    mready = 1'b1;
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    int cyc;
    mready = 1'b1; mrvalid = 1'b0;
    set_sw(v.mode, v.dev, v.mem, v.wdata);
    start = 1'b1;
    wait_mwvalid(ok);
    if (ok) begin
      chk($sformatf("v%0d_busy_issue", idx), 32'(busy), 32'd1);
      if (v.tmo) begin
        cyc = 0;
        while (busy && cyc < 40) begin tick(); cyc++; end
        chk($sformatf("v%0d_timeout_cycles", idx), 32'(cyc), 32'd9);
        chk($sformatf("v%0d_timeout_err", idx), 32'(timeout_err), 32'd1);
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_rdata_kept", idx), 32'(m_read_data), 32'(last_rdata));
      end else if (v.mode) begin
        finish_write($sformatf("v%0d", idx));
        chk($sformatf("v%0d_timeout_err", idx), 32'(timeout_err), 32'd0);
      end else begin
        tick(); mready = 1'b0;
        repeat (2) tick();
        mready = 1'b1; mrvalid = 1'b1; mrdata = v.rdata;
        tick();
        mrvalid = 1'b0;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_rdata", idx), 32'(m_read_data), 32'(v.rdata));
        chk($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_timeout_err", idx), 32'(timeout_err), 32'd0);
        last_rdata = v.rdata;
      end
    end
    start = 1'b0;
    repeat (10) tick();
    chk($sformatf("v%0d_maddr_hold", idx), 32'(maddr), 32'(v.exp_addr));
    chk($sformatf("v%0d_idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int p0;
    vecs[0] = '{1'b1, 2'b01, 6'h05, 8'hA5, 8'h00, 1'b0, 16'h0405};
    vecs[1] = '{1'b0, 2'b10, 6'h3F, 8'h11, 8'h3C, 1'b0, 16'h083F};
    vecs[2] = '{1'b0, 2'b11, 6'h2A, 8'h00, 8'h00, 1'b1, 16'h0C2A};
    vecs[3] = '{1'b1, 2'b00, 6'h3F, 8'h5A, 8'h00, 1'b0, 16'h003F};
    vecs[4] = '{1'b0, 2'b01, 6'h00, 8'h22, 8'hC3, 1'b0, 16'h0400};
    vecs[5] = '{1'b1, 2'b10, 6'h01, 8'hFF, 8'h00, 1'b1, 16'h0801};

    rstn = 1'b0; start = 1'b0; mode_sw = 1'b0; device_addr_sw = '0;
    slave_mem_addr_sw = '0; m_write_data_sw = '0; mready = 1'b1; mrvalid = 1'b0; mrdata = '0;
    repeat (3) tick();
    chk("reset_outputs", {maddr, mwdata, wen, mwvalid, busy, done, timeout_err}, 32'd0);
    chk("reset_rdata", 32'(m_read_data), 32'd0);
    rstn = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Bounce every 2 cycles, then hold: exactly one request.
    p0 = n_pulse;
    set_sw(1'b1, 2'b01, 6'h05, 8'h77);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; repeat (2) tick();
      start = 1'b0; repeat (2) tick();
    end
    start = 1'b1;
    wait_mwvalid(ok);
    if (ok) finish_write("bounce");
    repeat (20) tick();
    start = 1'b0;
    repeat (10) tick();
    chk("bounce_pulses", 32'(n_pulse - p0), 32'd1);

    // Pulses shorter than the debounce window alone: nothing.
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; repeat (3) tick();
      start = 1'b0; repeat (6) tick();
    end
    chk("short_pulses", 32'(n_pulse - p0), 32'd0);
    chk("short_idle", 32'(busy), 32'd0);

    // ARM hold: mready low at press, raised 10 cycles later.
    mready = 1'b0;
    set_sw(1'b1, 2'b00, 6'h11, 8'h3E);
    start = 1'b1;
    wait_busy();
    p0 = n_pulse;
    repeat (10) tick();
    chk("arm_no_issue", 32'(n_pulse - p0), 32'd0);
    chk("arm_done_cleared", 32'(done), 32'd0);
    mready = 1'b1;
    tick();
    chk("arm_issue_next", 32'(mwvalid), 32'd1);
    finish_write("arm");
    start = 1'b0;
    repeat (10) tick();

    // Release and re-press while busy: ignored, not queued.
    p0 = n_pulse;
    mready = 1'b0;
    set_sw(1'b1, 2'b11, 6'h3F, 8'h81);
    start = 1'b1;
    wait_busy();
    start = 1'b0; repeat (10) tick();
    start = 1'b1; repeat (10) tick();
    start = 1'b0; repeat (10) tick();
    mready = 1'b1;
    tick();
    chk("ignore_issue", 32'(mwvalid), 32'd1);
    finish_write("ignore");
    repeat (20) tick();
    chk("ignore_pulses", 32'(n_pulse - p0), 32'd1);
    chk("ignore_idle", 32'(busy), 32'd0);

    // Reset while in WAIT_DONE of a read.
    set_sw(1'b0, 2'b10, 6'h05, 8'h00);
    start = 1'b1;
    wait_mwvalid(ok);
    start = 1'b0;
    tick(); mready = 1'b0;
    repeat (2) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    tick();
    chk("midreset_outputs", {maddr, mwdata, wen, mwvalid, busy, done, timeout_err}, 32'd0);
    chk("midreset_rdata", 32'(m_read_data), 32'd0);
    rstn = 1'b1; mready = 1'b1;
    repeat (2) tick();
    p0 = n_pulse;
    mrvalid = 1'b1; mrdata = 8'h55;
    tick();
    mrvalid = 1'b0;
    tick();
    chk("post_reset_done", 32'(done), 32'd0);
    chk("post_reset_rdata", 32'(m_read_data), 32'd0);
    repeat (20) tick();
    chk("post_reset_no_issue", 32'(n_pulse - p0), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
